// File: rtl/dsp_fe_capture_ctrl.sv
// Capture sequencer: arm -> optional trigger wait -> programmable delay -> contiguous write burst.
// Optional trigger-wait timeout is compiled in with `define DSP_FE_CAP_TIMEOUT_EN.
module dsp_fe_capture_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DLY_WIDTH  = 16,
  parameter int TO_WIDTH   = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic                  i_trig,
  input  logic                  i_trig_sel,
  input  logic [DLY_WIDTH-1:0]  i_dly,
  input  logic [ADDR_WIDTH-1:0] i_len,
  input  logic [TO_WIDTH-1:0]   i_timeout,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_DELAY = 3'd2,
    S_CAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DLY_WIDTH-1:0]  r_dly, r_dly_cnt, w_dly_cnt_nxt, w_trig_dly;
  logic [ADDR_WIDTH-1:0] r_len, r_addr, w_addr_nxt;
  logic                  w_latch, w_trig_evt;

`ifdef DSP_FE_CAP_TIMEOUT_EN
  logic [TO_WIDTH-1:0]   r_to_lim, r_to_cnt, w_to_cnt_nxt;
  logic                  r_to_flag, w_to_flag_nxt;
`else
  logic                  w_unused_timeout;
  assign w_unused_timeout = ^i_timeout;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_dly_cnt_nxt = r_dly_cnt;
    w_addr_nxt    = r_addr;
    w_latch       = 1'b0;
    w_trig_evt    = 1'b0;
    w_trig_dly    = r_dly;
`ifdef DSP_FE_CAP_TIMEOUT_EN
    w_to_cnt_nxt  = r_to_cnt;
    w_to_flag_nxt = r_to_flag;
`endif
    if (i_abort) begin
      w_state_nxt   = S_IDLE;
      w_dly_cnt_nxt = '0;
      w_addr_nxt    = '0;
`ifdef DSP_FE_CAP_TIMEOUT_EN
      w_to_cnt_nxt  = '0;
      w_to_flag_nxt = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            w_latch    = 1'b1;
            w_addr_nxt = '0;
`ifdef DSP_FE_CAP_TIMEOUT_EN
            w_to_flag_nxt = 1'b0;
            w_to_cnt_nxt  = TO_WIDTH'(1);
`endif
            if (i_trig_sel) begin
              w_state_nxt = S_WAIT;
            end else begin
              // Self-trigger uses the delay being latched this same cycle.
              w_trig_evt = 1'b1;
              w_trig_dly = i_dly;
            end
          end
        end
        S_WAIT: begin
          if (i_trig) begin
            w_trig_evt = 1'b1;
`ifdef DSP_FE_CAP_TIMEOUT_EN
          end else if (r_to_lim != '0 && r_to_cnt == r_to_lim) begin
            w_state_nxt   = S_DONE;
            w_to_flag_nxt = 1'b1;
          end else begin
            w_to_cnt_nxt = r_to_cnt + TO_WIDTH'(1);
`endif
          end
        end
        S_DELAY: begin
          w_dly_cnt_nxt = r_dly_cnt - DLY_WIDTH'(1);
          if (r_dly_cnt == DLY_WIDTH'(1)) w_state_nxt = S_CAP;
        end
        S_CAP: begin
          if (r_addr == r_len) w_state_nxt = S_DONE;
          else                 w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_trig_evt) begin
        if (w_trig_dly == '0) begin
          w_state_nxt = S_CAP;
        end else begin
          w_state_nxt   = S_DELAY;
          w_dly_cnt_nxt = w_trig_dly;
        end
      end
    end
  end

  // i_en low freezes every register, including the latched configuration.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_dly_cnt <= '0;
      r_addr    <= '0;
      r_dly     <= '0;
      r_len     <= '0;
`ifdef DSP_FE_CAP_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_to_lim  <= '0;
      r_to_flag <= 1'b0;
`endif
    end else if (i_en) begin
      r_state   <= w_state_nxt;
      r_dly_cnt <= w_dly_cnt_nxt;
      r_addr    <= w_addr_nxt;
`ifdef DSP_FE_CAP_TIMEOUT_EN
      r_to_cnt  <= w_to_cnt_nxt;
      r_to_flag <= w_to_flag_nxt;
`endif
      if (w_latch) begin
        r_dly <= i_dly;
        r_len <= i_len;
`ifdef DSP_FE_CAP_TIMEOUT_EN
        r_to_lim <= i_timeout;
`endif
      end
    end
  end

  assign o_mem_we   = (r_state == S_CAP) && i_en;
  assign o_mem_addr = r_addr;
  assign o_busy     = (r_state == S_WAIT) || (r_state == S_DELAY) || (r_state == S_CAP);
  assign o_done     = (r_state == S_DONE);
  assign o_state    = r_state;
`ifdef DSP_FE_CAP_TIMEOUT_EN
  assign o_timeout  = r_to_flag;
`else
  assign o_timeout  = 1'b0;
`endif

endmodule
